// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Holds the FSM state enum, the PIO word address and the idle bus values.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        HOLD
    } led_state_t;

    localparam int          AVM_DATA_W = 32;
    localparam logic [1:0]  LED_PIO_ADDR = 2'd0;

    // Bus values driven whenever no PIO access is in progress
    localparam logic                  AVM_IDLE_CS      = 1'b0;
    localparam logic                  AVM_IDLE_WRITE_N = 1'b1;
    localparam logic [AVM_DATA_W-1:0] AVM_IDLE_WDATA   = '0;

endpackage

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after pointer.
// Ports: req, pointer in; pick (one-hot), index, valid (any req) out.
module led_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    int slot;

    always_comb begin
        pick  = '0;
        index = '0;
        valid = 1'b0;
        slot  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = (int'(pointer) + k) % NUM_REQ;
            if (!valid && req[slot]) begin
                valid      = 1'b1;
                pick[slot] = 1'b1;
                index      = IDX_W'(slot);
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM master sharing one LED PIO between NUM_REQ round-robin requesters.
// Ports: clk, reset_n (async low), req/req_data in; grant, busy, owner out;
//        avm_address/chipselect/write_n/writedata out, avm_readdata in;
//        err_clr in, verify_err out.
// Optional feature macro: LED_READBACK_EN adds a READ verify cycle.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic [1:0]                  avm_address,
    output logic                        avm_chipselect,
    output logic                        avm_write_n,
    output logic [AVM_DATA_W-1:0]       avm_writedata,
    input  logic [AVM_DATA_W-1:0]       avm_readdata,
    input  logic                        err_clr,
    output logic                        verify_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

    led_state_t              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [DATA_W-1:0]       pat_q, pat_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic                    cs_q, cs_d;
    logic                    wn_q, wn_d;
    logic [AVM_DATA_W-1:0]   wd_q, wd_d;

    logic [NUM_REQ-1:0]      pick;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_vld;

    led_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .pointer (ptr_q),
        .pick    (pick),
        .index   (pick_idx),
        .valid   (pick_vld)
    );

`ifdef LED_READBACK_EN
    logic verr_q, verr_d;
    logic mismatch;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        grant_d = '0;
        cs_d    = AVM_IDLE_CS;
        wn_d    = AVM_IDLE_WRITE_N;
        wd_d    = AVM_IDLE_WDATA;
`ifdef LED_READBACK_EN
        verr_d   = verr_q;
        mismatch = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // Bus registers are loaded here so they are live in WRITE
                if (pick_vld) begin
                    state_d = WRITE;
                    pat_d   = req_data[pick_idx*DATA_W +: DATA_W];
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ?
                              '0 : pick_idx + 1'b1;
                    grant_d = pick;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    wd_d    = {{(AVM_DATA_W-DATA_W){1'b0}},
                               req_data[pick_idx*DATA_W +: DATA_W]};
                end
            end
            WRITE: begin
`ifdef LED_READBACK_EN
                state_d = READ;
                cs_d    = 1'b1;
`else
                state_d = (HOLD_CYCLES == 0) ? IDLE : HOLD;
                cnt_d   = HOLD_LOAD;
`endif
            end
            READ: begin
`ifdef LED_READBACK_EN
                mismatch = (avm_readdata[DATA_W-1:0] != pat_q);
                state_d  = (HOLD_CYCLES == 0) ? IDLE : HOLD;
                cnt_d    = HOLD_LOAD;
`else
                state_d = IDLE;
`endif
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef LED_READBACK_EN
        // Clearing wins over a mismatch seen in the same cycle
        if (err_clr) begin
            verr_d = 1'b0;
        end else if (mismatch) begin
            verr_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            cs_q    <= AVM_IDLE_CS;
            wn_q    <= AVM_IDLE_WRITE_N;
            wd_q    <= AVM_IDLE_WDATA;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wd_q    <= wd_d;
        end
    end

`ifdef LED_READBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            verr_q <= 1'b0;
        end else begin
            verr_q <= verr_d;
        end
    end

    assign verify_err = verr_q;
`else
    // Readback path absent: these inputs have no function in this build
    logic unused_readback;
    assign unused_readback = ^{avm_readdata, err_clr};
    assign verify_err      = 1'b0;
`endif

    assign grant          = grant_q;
    assign busy           = (state_q != IDLE);
    assign owner          = owner_q;
    assign avm_address    = LED_PIO_ADDR;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wd_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: two sequencers (hold 4 and hold 0) on shared stimulus,
// each with its own PIO model, checked every cycle against a transaction model.
module tb_led_pattern_sequencer;

`ifdef LED_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        err_clr = 1'b0;

    logic [3:0]  grant_o [2];
    logic        busy_o  [2];
    logic [1:0]  owner_o [2];
    logic [1:0]  addr_o  [2];
    logic        cs_o    [2];
    logic        wn_o    [2];
    logic [31:0] wd_o    [2];
    logic [31:0] rd_i    [2];
    logic        verr_o  [2];
    logic [7:0]  led     [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(4), .CNT_W(4)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .grant(grant_o[0]), .busy(busy_o[0]), .owner(owner_o[0]),
        .avm_address(addr_o[0]), .avm_chipselect(cs_o[0]),
        .avm_write_n(wn_o[0]), .avm_writedata(wd_o[0]),
        .avm_readdata(rd_i[0]), .err_clr(err_clr), .verify_err(verr_o[0])
    );

    led_pattern_sequencer #(
        .NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(0), .CNT_W(4)
    ) u_dut_h0 (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .grant(grant_o[1]), .busy(busy_o[1]), .owner(owner_o[1]),
        .avm_address(addr_o[1]), .avm_chipselect(cs_o[1]),
        .avm_write_n(wn_o[1]), .avm_writedata(wd_o[1]),
        .avm_readdata(rd_i[1]), .err_clr(err_clr), .verify_err(verr_o[1])
    );

    // PIO models: not reset by reset_n; pattern 3C reads back corrupted
    initial begin
        led[0] = 8'h00;
        led[1] = 8'h00;
    end
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++)
            if (cs_o[m] && !wn_o[m]) led[m] <= wd_o[m][7:0];
    end
    assign rd_i[0] = (led[0] == 8'h3C) ? 32'h0 : {24'h0, led[0]};
    assign rd_i[1] = (led[1] == 8'h3C) ? 32'h0 : {24'h0, led[1]};

    function automatic int hc(input int m);
        return (m == 0) ? 4 : 0;
    endfunction

    // Transaction model: rem = cycles of the current transaction left,
    // pos = cycle index inside it (0 = write, 1 = read when enabled)
    int         rem  [2] = '{0, 0};
    int         pos  [2] = '{0, 0};
    int         ptr  [2] = '{0, 0};
    int         mown [2] = '{0, 0};
    logic [7:0] pat  [2] = '{8'h0, 8'h0};
    logic       mverr[2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge reset_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!reset_n) begin
                rem[m] = 0; pos[m] = 0; ptr[m] = 0;
                mown[m] = 0; pat[m] = 8'h0; mverr[m] = 1'b0;
            end else begin
                logic mis;
                mis = (RB == 1) && rem[m] > 0 && pos[m] == 1
                      && rd_i[m][7:0] != pat[m];
                if (err_clr) mverr[m] = 1'b0;
                else if (mis) mverr[m] = 1'b1;
                if (rem[m] > 0) begin
                    rem[m]--;
                    pos[m]++;
                end else if (req != 4'b0) begin
                    for (int k = 0; k < N; k++) begin
                        int j;
                        j = (ptr[m] + k) % N;
                        if (rem[m] == 0 && req[j]) begin
                            mown[m] = j;
                            pat[m]  = req_data[j*8 +: 8];
                            ptr[m]  = (j + 1) % N;
                            rem[m]  = 1 + RB + hc(m);
                            pos[m]  = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int m,
                       input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h at %0t", nm, m, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic ew, er;
            ew = rem[m] > 0 && pos[m] == 0;
            er = (RB == 1) && rem[m] > 0 && pos[m] == 1;
            chk("busy", m, 32'(busy_o[m]), 32'(rem[m] > 0));
            chk("grant", m, 32'(grant_o[m]), ew ? 32'(1 << mown[m]) : 32'h0);
            chk("owner", m, 32'(owner_o[m]), 32'(mown[m]));
            chk("address", m, 32'(addr_o[m]), 32'h0);
            chk("chipselect", m, 32'(cs_o[m]), 32'(ew || er));
            chk("write_n", m, 32'(wn_o[m]), 32'(!ew));
            chk("writedata", m, wd_o[m], ew ? {24'h0, pat[m]} : 32'h0);
            chk("verify_err", m, 32'(verr_o[m]), 32'(mverr[m]));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        err_clr = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input int m, input int lim);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            tick();
            if (grant_o[m] != 4'b0) ok = 1'b1;
        end
        chk("grant_seen", m, 32'(ok), 32'h1);
    endtask

    task automatic wait_idle(input int m, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!busy_o[m]) break;
            n++;
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin
        int n;
        int writes;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_busy", 0, 32'(busy_o[0]), 32'h0);
        chk("rst_owner", 0, 32'(owner_o[0]), 32'h0);
        chk("rst_cs", 0, 32'(cs_o[0]), 32'h0);
        chk("rst_write_n", 0, 32'(wn_o[0]), 32'h1);

        // single request
        req_data = 32'h0000A500;
        req = 4'b0010;
        wait_grant(0, 10);
        req = 4'b0000;
        chk("single_grant", 0, 32'(grant_o[0]), 32'h2);
        chk("single_wdata", 0, wd_o[0], 32'h000000A5);
        chk("model_pat", 0, 32'(pat[0]), 32'hA5);
        wait_idle(0, n);
        chk("hold_len", 0, 32'(n), 32'(4 + RB));

        // fairness from a fresh pointer
        do_reset();
        req_data = 32'h44332211;
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_grant(0, 20);
            chk("rr_order", 0, 32'(idx_of(grant_o[0])), 32'(g % 4));
            chk("rr_data", 0, wd_o[0], 32'((g % 4 + 1) * 17));
        end

        // no hold: write to write spacing
        do_reset();
        req = 4'hF;
        wait_grant(1, 10);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (grant_o[1] != 4'b0) break;
        end
        chk("gap_hold0", 1, 32'(n), 32'(2 + RB));

        // changes during hold are ignored
        do_reset();
        req_data = 32'h000000C3;
        req = 4'b0001;
        wait_grant(0, 10);
        chk("hold_wdata", 0, wd_o[0], 32'h000000C3);
        req = 4'b0000;
        req_data = 32'hFFFFFFFF;
        writes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cs_o[0] && !wn_o[0]) writes++;
            if (!busy_o[0]) break;
        end
        chk("hold_writes", 0, 32'(writes), 32'h0);
        chk("pio_kept", 0, 32'(led[0]), 32'hC3);

        // reset in the middle of hold
        req_data = 32'h00770000;
        req = 4'b0100;
        wait_grant(0, 10);
        req = 4'b0000;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk("mid_rst_busy", 0, 32'(busy_o[0]), 32'h0);
        chk("mid_rst_owner", 0, 32'(owner_o[0]), 32'h0);
        chk("mid_rst_cs", 0, 32'(cs_o[0]), 32'h0);
        reset_n = 1'b1;
        req = 4'hF;
        wait_grant(0, 10);
        chk("post_rst_grant", 0, 32'(grant_o[0]), 32'h1);
        req = 4'b0000;
        wait_idle(0, n);

`ifdef LED_READBACK_EN
        do_reset();
        req_data = 32'h0000003C;
        req = 4'b0001;
        wait_grant(0, 10);
        req = 4'b0000;
        wait_idle(0, n);
        chk("verr_set", 0, 32'(verr_o[0]), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("verr_clr", 0, 32'(verr_o[0]), 32'h0);
        req_data = 32'h0000005A;
        req = 4'b0001;
        wait_grant(0, 10);
        req = 4'b0000;
        wait_idle(0, n);
        chk("verr_match", 0, 32'(verr_o[0]), 32'h0);
`endif

        // random traffic with occasional resets and clears
        do_reset();
        for (int i = 0; i < 800; i++) begin
            req      = 4'($urandom_range(0, 15));
            req_data = $urandom;
            if ($urandom_range(0, 7) == 0) req_data[7:0] = 8'h3C;
            err_clr  = ($urandom_range(0, 19) == 0);
            reset_n  = ($urandom_range(0, 149) != 0);
            tick();
        end
        reset_n = 1'b1;
        req = 4'b0000;
        err_clr = 1'b0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
